// File: rtl/servo_pwm_driver_pkg.sv
// Shared servo constants, duty type and command clamp.
// Also imported by the arm sequencer for LEFT/MIDDLE/RIGHT.
package servo_pkg;

  localparam int DUTY_W     = 21;
  localparam int PERIOD     = 2_000_000;
  localparam int MIN_DUTY   = 50_000;
  localparam int MAX_DUTY   = 250_000;
  localparam int RESET_DUTY = 150_000;
  localparam int RAMP_STEP  = 10_000;
  localparam int LEFT       = 80_000;
  localparam int MIDDLE     = 150_000;
  localparam int RIGHT      = 240_000;

  typedef logic [DUTY_W-1:0] duty_t;

  // 0 releases the channel; other values are forced into [lo, hi].
  function automatic duty_t clamp_duty(
    input duty_t d,
    input duty_t lo,
    input duty_t hi
  );
    duty_t r;
    if (d == '0)    r = '0;
    else if (d < lo) r = lo;
    else if (d > hi) r = hi;
    else            r = d;
    return r;
  endfunction

endpackage

// File: rtl/servo_pwm_driver_if.sv
// Sequencer <-> PWM driver command/status bundle.
// master = sequencer side, slave = servo_pwm_driver.
interface servo_pwm_driver_if
  import servo_pkg::*;
#(
  parameter int NUM_SERVOS = 4
);

  logic                  EnablePWM;
  logic [1:0]            ServoNum;
  duty_t                 ActiveServoDuty;
  logic [NUM_SERVOS-1:0] ServoPWM;
  logic                  ActivePeriodFinished;

  modport master (
    output EnablePWM,
    output ServoNum,
    output ActiveServoDuty,
    input  ServoPWM,
    input  ActivePeriodFinished
  );

  modport slave (
    input  EnablePWM,
    input  ServoNum,
    input  ActiveServoDuty,
    output ServoPWM,
    output ActivePeriodFinished
  );

endinterface

// File: rtl/servo_pwm_driver_channel.sv
// One servo channel: duty (and optional ramp) registers plus compare.
// Ports: en_i, cnt_i frame counter, bnd_i boundary, we_i/duty_i write, pwm_o.
// SERVO_SOFT_RAMP_EN: target/current pair, current steps RAMP_STEP per frame.
module servo_pwm_channel
  import servo_pkg::*;
#(
  parameter int RESET_DUTY = servo_pkg::RESET_DUTY,
  parameter int RAMP_STEP  = servo_pkg::RAMP_STEP
) (
  input  logic  clk,
  input  logic  rst_n_i,
  input  logic  en_i,
  input  duty_t cnt_i,
  input  logic  bnd_i,
  input  logic  we_i,
  input  duty_t duty_i,
  output logic  pwm_o
);

  localparam duty_t RST_D = DUTY_W'(RESET_DUTY);

  duty_t cur_q, cur_d;
  logic  pwm_q;

`ifdef SERVO_SOFT_RAMP_EN
  localparam duty_t STEP = DUTY_W'(RAMP_STEP);

  duty_t tgt_q, tgt_d;

  // The ramp uses the target written on this same boundary,
  // so the first step is visible in the very next frame.
  always_comb begin
    tgt_d = tgt_q;
    cur_d = cur_q;
    if (bnd_i) begin
      if (we_i) tgt_d = duty_i;
      if (tgt_d == '0)
        cur_d = '0;
      else if (tgt_d > cur_q)
        cur_d = (tgt_d - cur_q > STEP) ? cur_q + STEP : tgt_d;
      else if (tgt_d < cur_q)
        cur_d = (cur_q - tgt_d > STEP) ? cur_q - STEP : tgt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n_i) begin
      tgt_q <= RST_D;
      cur_q <= RST_D;
    end else begin
      tgt_q <= tgt_d;
      cur_q <= cur_d;
    end
  end
`else
  logic unused_ramp;
  assign unused_ramp = ^RAMP_STEP;

  always_comb begin
    cur_d = cur_q;
    if (bnd_i && we_i) cur_d = duty_i;
  end

  always_ff @(posedge clk) begin
    if (!rst_n_i) cur_q <= RST_D;
    else          cur_q <= cur_d;
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n_i) pwm_q <= 1'b0;
    else          pwm_q <= en_i && (cnt_i < cur_q);
  end

  assign pwm_o = pwm_q;

endmodule

// File: rtl/servo_pwm_driver.sv
// 50 Hz multi-servo PWM driver fed by the arm sequencer.
// Ports: clk, ResetN (sync, low), bus (slave: command in, PWM/strobe out).
// Optional SERVO_SOFT_RAMP_EN enables per-frame duty ramping.
module servo_pwm_driver
  import servo_pkg::*;
#(
  parameter int PERIOD     = servo_pkg::PERIOD,
  parameter int MIN_DUTY   = servo_pkg::MIN_DUTY,
  parameter int MAX_DUTY   = servo_pkg::MAX_DUTY,
  parameter int RESET_DUTY = servo_pkg::RESET_DUTY,
  parameter int NUM_SERVOS = 4,
  parameter int RAMP_STEP  = servo_pkg::RAMP_STEP
) (
  input logic          clk,
  input logic          ResetN,
  servo_pwm_driver_if.slave bus
);

  if (MAX_DUTY >= PERIOD || MIN_DUTY > MAX_DUTY ||
      NUM_SERVOS < 1 || NUM_SERVOS > 4) begin : g_bad_cfg
    $error("servo_pwm_driver: illegal duty/period configuration");
  end

  localparam duty_t LAST = DUTY_W'(PERIOD - 1);

  duty_t cnt_q, cnt_d;
  logic  apf_q;
  logic  wrap;
  logic  bnd;
  duty_t duty_c;
  logic [NUM_SERVOS-1:0] pwm;

  assign wrap = (cnt_q == LAST);
  // Dropping enable on the boundary edge suppresses the strobe and update.
  assign bnd  = bus.EnablePWM && wrap;

  always_comb begin
    cnt_d = '0;
    if (bus.EnablePWM && !wrap) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!ResetN) begin
      cnt_q <= '0;
      apf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      apf_q <= bnd;
    end
  end

  assign duty_c = clamp_duty(bus.ActiveServoDuty,
                             DUTY_W'(MIN_DUTY),
                             DUTY_W'(MAX_DUTY));

  // ServoNum values with no channel never match, so they are ignored.
  for (genvar i = 0; i < NUM_SERVOS; i++) begin : g_ch
    servo_pwm_channel #(
      .RESET_DUTY (RESET_DUTY),
      .RAMP_STEP  (RAMP_STEP)
    ) u_ch (
      .clk     (clk),
      .rst_n_i (ResetN),
      .en_i    (bus.EnablePWM),
      .cnt_i   (cnt_q),
      .bnd_i   (bnd),
      .we_i    (bus.ServoNum == 2'(i)),
      .duty_i  (duty_c),
      .pwm_o   (pwm[i])
    );
  end

  assign bus.ServoPWM             = pwm;
  assign bus.ActivePeriodFinished = apf_q;

endmodule
